// File: rtl/packed_mac_int_x2_if.sv
// ---------------------------------------------------------------------------
// packed_mac_int_x2_if
//
// Purpose: groups the sample stream and the result stream of the two-lane
// packed multiply-accumulate so that fetch logic, the MAC and the adder
// tree can be wired with a single connection.
//
// Parameters:
//   DW    signed operand width of a, b, c
//   ACCW  width of the two window sums
//
// Signals:
//   clear      synchronous flush of pipeline, window counter, accumulators
//   in_valid   a, b, c carry a sample this cycle
//   a, b       signed weights of lane A and lane B
//   c          signed activation shared by both lanes
//   out_valid  one-cycle pulse, a window has completed
//   out_ac     signed window sum of a*c
//   out_bc     signed window sum of b*c
//   busy       samples in flight or a window partially accumulated
//
// Modports:
//   master  the producer/consumer side (drives samples, reads results)
//   slave   the MAC itself
// ---------------------------------------------------------------------------
interface packed_mac_int_x2_if #(
    parameter int DW   = 4,
    parameter int ACCW = 16
);
    logic                   clear;
    logic                   in_valid;
    logic signed [DW-1:0]   a;
    logic signed [DW-1:0]   b;
    logic signed [DW-1:0]   c;
    logic                   out_valid;
    logic signed [ACCW-1:0] out_ac;
    logic signed [ACCW-1:0] out_bc;
    logic                   busy;

    modport master (
        output clear,
        output in_valid,
        output a,
        output b,
        output c,
        input  out_valid,
        input  out_ac,
        input  out_bc,
        input  busy
    );

    modport slave (
        input  clear,
        input  in_valid,
        input  a,
        input  b,
        input  c,
        output out_valid,
        output out_ac,
        output out_bc,
        output busy
    );
endinterface

// File: rtl/packed_mac_int_x2.sv
// ---------------------------------------------------------------------------
// packed_mac_int_x2
//
// Purpose: two-lane packed multiply-accumulate. Two signed weights a and b
// share one signed activation c. Each accepted sample is packed into a
// single operand (a * 2^(2*DW) + b), multiplied by c on one multiplier, and
// the product is split back into the exact lane products a*c and b*c. Both
// lanes are accumulated over LEN valid samples and the pair of window sums
// is presented with a one-cycle out_valid pulse. There is no backpressure
// and full-rate back-to-back windows run without bubbles.
//
// Pipeline (one register stage each):
//   S1  input capture
//   S2  packed multiply
//   S3  split and borrow correction
//   S4  accumulate, window counting
//   A sample accepted at edge t is accumulated at edge t+3; if it closes a
//   window the result registers appear at edge t+4.
//
// Parameters:
//   DW    signed operand width (4 or 8)
//   LEN   valid samples per window (>= 1)
//   ACCW  accumulator/output width, at least 2*DW + clog2(LEN); sums wrap
//         modulo 2^ACCW
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    packed_mac_int_x2_if slave modport (samples in, window sums out)
// ---------------------------------------------------------------------------
module packed_mac_int_x2 #(
    parameter int DW   = 4,
    parameter int LEN  = 9,
    parameter int ACCW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    packed_mac_int_x2_if.slave    bus
);

    // Lane b occupies the low 2*DW bits of the packed product, lane a sits
    // above it.
    localparam int S   = 2 * DW;
    // a*2^S + b can fall one step below the 3*DW signed range (a and b both
    // at their most negative), so the packed operand carries one spare bit.
    localparam int PW  = 3 * DW + 1;
    localparam int QW  = 4 * DW;
    localparam int PRW = 2 * DW;
    localparam int CW  = (LEN > 1) ? $clog2(LEN) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic                    s1_valid;
    logic signed [DW-1:0]    s1_a;
    logic signed [DW-1:0]    s1_b;
    logic signed [DW-1:0]    s1_c;

    logic                    s2_valid;
    logic signed [QW-1:0]    s2_q;

    logic                    s3_valid;
    logic signed [PRW-1:0]   s3_ac;
    logic signed [PRW-1:0]   s3_bc;

    logic [CW-1:0]           cnt;
    logic signed [ACCW-1:0]  acc_ac;
    logic signed [ACCW-1:0]  acc_bc;
    logic                    done;

    logic                    out_valid_q;
    logic signed [ACCW-1:0]  out_ac_q;
    logic signed [ACCW-1:0]  out_bc_q;

    // ------------------------------------------------------------------
    // Combinational datapath between stages
    // ------------------------------------------------------------------
    logic signed [PW-1:0]    packed_op;
    logic signed [QW-1:0]    packed_prod;
    logic        [PRW-1:0]   split_bc;
    logic        [PRW-1:0]   split_hi;
    logic        [PRW-1:0]   split_ac;
    logic signed [ACCW-1:0]  ext_ac;
    logic signed [ACCW-1:0]  ext_bc;
    logic                    cnt_is_first;
    logic                    cnt_is_last;

    // Packed operand: a shifted into the upper field, b sign-extended into
    // the lower field. Negative b borrows one from the a field, which the
    // split stage undoes.
    assign packed_op = (PW'(s1_a) <<< S) + PW'(s1_b);

    // The true packed product always fits in 4*DW signed bits, so a plain
    // 4*DW multiply is exact.
    assign packed_prod = QW'(packed_op) * QW'(s1_c);

    // Low field is b*c exactly. The high field is a*c minus one whenever
    // b*c is negative; adding the sign bit of b*c restores a*c.
    assign split_bc = s2_q[PRW-1:0];
    assign split_hi = s2_q[QW-1:S];
    assign split_ac = split_hi + {{(PRW-1){1'b0}}, split_bc[PRW-1]};

    // Lane products are sign-extended to the accumulator width.
    assign ext_ac = ACCW'(s3_ac);
    assign ext_bc = ACCW'(s3_bc);

    assign cnt_is_first = (cnt == '0);
    assign cnt_is_last  = (cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // S1: capture the incoming sample. A sample presented together with
    // clear is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
        end else begin
            s1_valid <= bus.in_valid & ~bus.clear;
            if (bus.in_valid) begin
                s1_a <= bus.a;
                s1_b <= bus.b;
                s1_c <= bus.c;
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: packed multiply.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else begin
            s2_valid <= s1_valid & ~bus.clear;
            if (s1_valid) begin
                s2_q <= packed_prod;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: split the packed product into the two lane products.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid <= 1'b0;
            s3_ac    <= '0;
            s3_bc    <= '0;
        end else begin
            s3_valid <= s2_valid & ~bus.clear;
            if (s2_valid) begin
                s3_ac <= split_ac;
                s3_bc <= split_bc;
            end
        end
    end

    // ------------------------------------------------------------------
    // S4: window counter and accumulators. The first sample of a window
    // loads the accumulator rather than adding, which lets the next window
    // start in the same cycle the previous result is registered. done marks
    // that the accumulator now holds a complete window.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_ac <= '0;
            acc_bc <= '0;
            done   <= 1'b0;
        end else if (bus.clear) begin
            cnt    <= '0;
            acc_ac <= '0;
            acc_bc <= '0;
            done   <= 1'b0;
        end else begin
            done <= s3_valid & cnt_is_last;
            if (s3_valid) begin
                if (cnt_is_first) begin
                    acc_ac <= ext_ac;
                    acc_bc <= ext_bc;
                end else begin
                    acc_ac <= acc_ac + ext_ac;
                    acc_bc <= acc_bc + ext_bc;
                end
                if (cnt_is_last) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers. The sums hold until the next window completes and
    // survive clear; only reset zeroes them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_ac_q    <= '0;
            out_bc_q    <= '0;
        end else if (bus.clear) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= done;
            if (done) begin
                out_ac_q <= acc_ac;
                out_bc_q <= acc_bc;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ac    = out_ac_q;
    assign bus.out_bc    = out_bc_q;

    // busy covers samples still travelling S1..S3 and a partially filled
    // window; the final S4-to-output hop is not included.
    assign bus.busy = (cnt != '0) | s1_valid | s2_valid | s3_valid;

endmodule

// File: tb/tb_packed_mac_int_x2.sv
// ---------------------------------------------------------------------------
// tb_packed_mac_int_x2
//
// Self-checking bench for packed_mac_int_x2. Three instances run side by
// side from one clock and one reset:
//   u0  DW=4 LEN=1 ACCW=16
//   u1  DW=4 LEN=9 ACCW=16
//   u2  DW=8 LEN=9 ACCW=20
// A reference model works with plain integer products and window sums:
// every accepted sample adds a*c and b*c to the running window, a full
// window schedules an expected result four edges after its last sample,
// clear drops everything not yet delivered, reset drops everything.
// Every cycle each instance's out_valid, out_ac, out_bc and busy are
// compared against the model; directed windows also compare against
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_packed_mac_int_x2;

    localparam int NI    = 3;
    localparam int DW0   = 4;
    localparam int LEN0  = 1;
    localparam int ACCW0 = 16;
    localparam int DW1   = 4;
    localparam int LEN1  = 9;
    localparam int ACCW1 = 16;
    localparam int DW2   = 8;
    localparam int LEN2  = 9;
    localparam int ACCW2 = 20;
    localparam int NP    = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    packed_mac_int_x2_if #(.DW(DW0), .ACCW(ACCW0)) bus0 ();
    packed_mac_int_x2_if #(.DW(DW1), .ACCW(ACCW1)) bus1 ();
    packed_mac_int_x2_if #(.DW(DW2), .ACCW(ACCW2)) bus2 ();

    packed_mac_int_x2 #(.DW(DW0), .LEN(LEN0), .ACCW(ACCW0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );
    packed_mac_int_x2 #(.DW(DW1), .LEN(LEN1), .ACCW(ACCW1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );
    packed_mac_int_x2 #(.DW(DW2), .LEN(LEN2), .ACCW(ACCW2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int cfg_dw   [NI] = '{DW0, DW1, DW2};
    int cfg_len  [NI] = '{LEN0, LEN1, LEN2};
    int cfg_accw [NI] = '{ACCW0, ACCW1, ACCW2};

    // values currently presented on each instance
    int drv_v   [NI];
    int drv_a   [NI];
    int drv_b   [NI];
    int drv_c   [NI];
    int drv_clr [NI];

    // reference model state
    int win_cnt [NI];
    int sum_ac  [NI];
    int sum_bc  [NI];
    int cum0    [NI];
    int cum1    [NI];
    int cum2    [NI];
    int cum3    [NI];
    int last_ac [NI];
    int last_bc [NI];
    int pd_ok   [NI][NP];
    int pd_due  [NI][NP];
    int pd_ac   [NI][NP];
    int pd_bc   [NI][NP];
    int edge_no;

    int checks;
    int errors;

    function automatic int wrapw(int x, int w);
        int t;
        t = x <<< (32 - w);
        return t >>> (32 - w);
    endfunction

    function automatic int rnd_s(int w);
        return int'($urandom_range((1 << w) - 1, 0)) - (1 << (w - 1));
    endfunction

    function automatic int obs_valid(int k);
        case (k)
            0:       return int'(bus0.out_valid);
            1:       return int'(bus1.out_valid);
            default: return int'(bus2.out_valid);
        endcase
    endfunction

    function automatic int obs_busy(int k);
        case (k)
            0:       return int'(bus0.busy);
            1:       return int'(bus1.busy);
            default: return int'(bus2.busy);
        endcase
    endfunction

    function automatic int obs_ac(int k);
        case (k)
            0:       return int'(bus0.out_ac);
            1:       return int'(bus1.out_ac);
            default: return int'(bus2.out_ac);
        endcase
    endfunction

    function automatic int obs_bc(int k);
        case (k)
            0:       return int'(bus0.out_bc);
            1:       return int'(bus1.out_bc);
            default: return int'(bus2.out_bc);
        endcase
    endfunction

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input int v, input int a,
                                 input int b, input int c, input int clr);
        drv_v[k]   = v;
        drv_a[k]   = a;
        drv_b[k]   = b;
        drv_c[k]   = c;
        drv_clr[k] = clr;
        case (k)
            0: begin
                bus0.in_valid = (v != 0);
                bus0.clear    = (clr != 0);
                bus0.a        = a[DW0-1:0];
                bus0.b        = b[DW0-1:0];
                bus0.c        = c[DW0-1:0];
            end
            1: begin
                bus1.in_valid = (v != 0);
                bus1.clear    = (clr != 0);
                bus1.a        = a[DW1-1:0];
                bus1.b        = b[DW1-1:0];
                bus1.c        = c[DW1-1:0];
            end
            default: begin
                bus2.in_valid = (v != 0);
                bus2.clear    = (clr != 0);
                bus2.a        = a[DW2-1:0];
                bus2.b        = b[DW2-1:0];
                bus2.c        = c[DW2-1:0];
            end
        endcase
    endtask

    task automatic idleAll();
        for (int k = 0; k < NI; k++) applyStimulus(k, 0, 0, 0, 0, 0);
    endtask

    task automatic modelReset(input int k);
        win_cnt[k] = 0;
        sum_ac[k]  = 0;
        sum_bc[k]  = 0;
        cum0[k]    = 0;
        cum1[k]    = 0;
        cum2[k]    = 0;
        cum3[k]    = 0;
        last_ac[k] = 0;
        last_bc[k] = 0;
        for (int j = 0; j < NP; j++) pd_ok[k][j] = 0;
    endtask

    // Model update for one rising edge, using what the bench presented.
    task automatic modelEdge();
        edge_no++;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                modelReset(k);
            end else if (drv_clr[k] != 0) begin
                for (int j = 0; j < NP; j++)
                    if (pd_ok[k][j] != 0 && pd_due[k][j] >= edge_no) pd_ok[k][j] = 0;
                win_cnt[k] = 0;
                sum_ac[k]  = 0;
                sum_bc[k]  = 0;
                cum0[k]    = 0;
                cum1[k]    = 0;
                cum2[k]    = 0;
                cum3[k]    = 0;
            end else begin
                cum3[k] = cum2[k];
                cum2[k] = cum1[k];
                cum1[k] = cum0[k];
                if (drv_v[k] != 0) begin
                    sum_ac[k] += drv_a[k] * drv_c[k];
                    sum_bc[k] += drv_b[k] * drv_c[k];
                    win_cnt[k]++;
                    cum0[k]++;
                    if (win_cnt[k] == cfg_len[k]) begin
                        for (int j = 0; j < NP; j++) begin
                            if (pd_ok[k][j] == 0) begin
                                pd_ok[k][j]  = 1;
                                pd_due[k][j] = edge_no + 4;
                                pd_ac[k][j]  = wrapw(sum_ac[k], cfg_accw[k]);
                                pd_bc[k][j]  = wrapw(sum_bc[k], cfg_accw[k]);
                                break;
                            end
                        end
                        win_cnt[k] = 0;
                        sum_ac[k]  = 0;
                        sum_bc[k]  = 0;
                    end
                end
            end
        end
    endtask

    // Compare every instance against the model after the current edge.
    task automatic checkAll();
        for (int k = 0; k < NI; k++) begin
            int ev;
            int eb;
            ev = 0;
            for (int j = 0; j < NP; j++) begin
                if (pd_ok[k][j] != 0 && pd_due[k][j] == edge_no) begin
                    ev          = 1;
                    last_ac[k]  = pd_ac[k][j];
                    last_bc[k]  = pd_bc[k][j];
                    pd_ok[k][j] = 0;
                end
            end
            eb = ((cum3[k] % cfg_len[k]) != 0 || cum0[k] != cum3[k]) ? 1 : 0;
            checkOutput($sformatf("u%0d_valid_e%0d", k, edge_no), obs_valid(k), ev);
            checkOutput($sformatf("u%0d_ac_e%0d", k, edge_no), obs_ac(k), last_ac[k]);
            checkOutput($sformatf("u%0d_bc_e%0d", k, edge_no), obs_bc(k), last_bc[k]);
            checkOutput($sformatf("u%0d_busy_e%0d", k, edge_no), obs_busy(k), eb);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    task automatic checkZeros(input string tag);
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("%s_u%0d_valid", tag, k), obs_valid(k), 0);
            checkOutput($sformatf("%s_u%0d_ac", tag, k), obs_ac(k), 0);
            checkOutput($sformatf("%s_u%0d_bc", tag, k), obs_bc(k), 0);
            checkOutput($sformatf("%s_u%0d_busy", tag, k), obs_busy(k), 0);
        end
    endtask

    // Idles until instance k pulses (bounded) and compares the sums with
    // hand-computed constants.
    task automatic waitPulse(input int k, input int limit, input int exp_ac,
                             input int exp_bc, input string tag);
        int got;
        got = 0;
        for (int i = 0; i < limit && got == 0; i++) begin
            cycle();
            if (obs_valid(k) == 1) got = 1;
        end
        checkOutput({tag, "_pulse"}, got, 1);
        if (got != 0) begin
            checkOutput({tag, "_ac"}, obs_ac(k), exp_ac);
            checkOutput({tag, "_bc"}, obs_bc(k), exp_bc);
        end
    endtask

    task automatic feed(input int k, input int n, input int a, input int b, input int c);
        for (int i = 0; i < n; i++) begin
            applyStimulus(k, 1, a, b, c, 0);
            cycle();
        end
        applyStimulus(k, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        edge_no = 0;
        for (int k = 0; k < NI; k++) modelReset(k);
        idleAll();

        // reset state
        #1 rst_n = 1'b0;
        #1 checkZeros("reset_async");
        cycle();
        cycle();
        checkZeros("reset_held");
        rst_n = 1'b1;
        cycle();

        // LEN=1, borrow correction and operand extremes
        feed(0, 1, 3, -2, 5);
        waitPulse(0, 8, 15, -10, "single");
        feed(0, 1, -8, -8, -8);
        waitPulse(0, 8, 64, 64, "ext_neg");
        feed(0, 1, 7, -8, 7);
        waitPulse(0, 8, 49, -56, "ext_mix");

        // full LEN=9 window
        feed(1, 9, 7, -8, -8);
        waitPulse(1, 8, -504, 576, "full_win");

        // 18 samples with a gap every third cycle, then a full-rate window
        begin
            int acc;
            int cyc;
            acc = 0;
            cyc = 0;
            while (acc < 18) begin
                if (cyc % 3 == 2) begin
                    applyStimulus(1, 0, 0, 0, 0, 0);
                end else begin
                    applyStimulus(1, 1, 1, 1, 1, 0);
                    acc++;
                end
                cycle();
                cyc++;
            end
        end
        feed(1, 9, 1, -1, 2);
        waitPulse(1, 8, 18, -18, "b2b_win2");

        // clear in the middle of a window
        feed(1, 5, 5, -3, 4);
        applyStimulus(1, 1, 7, 7, 7, 1);
        cycle();
        feed(1, 9, 2, 3, 1);
        waitPulse(1, 8, 18, 27, "after_clear");

        // asynchronous reset in the middle of a window
        feed(1, 5, 5, -3, 4);
        #2 rst_n = 1'b0;
        #1 checkZeros("reset_mid");
        for (int k = 0; k < NI; k++) modelReset(k);
        cycle();
        cycle();
        rst_n = 1'b1;
        feed(1, 9, 2, 3, 1);
        waitPulse(1, 8, 18, 27, "after_reset");

        // DW=8 extremes, 9 x (-128)*(-128)
        applyStimulus(2, 0, 0, 0, 0, 1);
        cycle();
        feed(2, 9, -128, -128, -128);
        waitPulse(2, 8, 147456, 147456, "dw8_ext");

        // randomised traffic on all instances
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NI; k++) begin
                int v;
                int clr;
                v   = ($urandom_range(3, 0) != 0) ? 1 : 0;
                clr = ($urandom_range(59, 0) == 0) ? 1 : 0;
                if ($urandom_range(15, 0) == 0)
                    applyStimulus(k, v, -(1 << (cfg_dw[k] - 1)), -(1 << (cfg_dw[k] - 1)),
                                  -(1 << (cfg_dw[k] - 1)), clr);
                else
                    applyStimulus(k, v, rnd_s(cfg_dw[k]), rnd_s(cfg_dw[k]),
                                  rnd_s(cfg_dw[k]), clr);
            end
            cycle();
        end
        idleAll();
        for (int n = 0; n < 10; n++) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
